// File: rtl/cfg_reg_bank.sv
// Configuration register bank with a start/done handshake to a processing core.
//
// Register map (16-bit registers, byte-split data buses):
//   0x00        ID       RO  returns CHIP_ID
//   0x01        CTRL     bit0 START (pulse), bit1 SOFT_RST (pulse), bit8 IRQ_EN (RW)
//   0x02        STATUS   bit0 BUSY, bit1 DONE (W1C), bit2 ERR (W1C), [15:8] DONE_CNT
//   0x03        SCRATCH  RW
//   0x10+k      CFG[k]   RW, k < NUM_CFG; writes while BUSY are dropped and flag ERR
//   others      read 0, writes ignored
//
// Ports:
//   CLK, rst_n                  clock (rising edge), asynchronous active-low reset
//   reg_ce, reg_we              access strobe and write select
//   reg_addr_0b                 register address
//   reg_wdata_0b/1b             write data [7:0]/[15:8]
//   reg_rdata_0b/1b             registered read data [7:0]/[15:8], 1-cycle latency
//   cfg_out                     packed CFG contents, CFG[k] at [16k+15:16k]
//   core_start / core_done      one-cycle start pulse out / completion pulse in
//   irq                         registered level interrupt
module cfg_reg_bank #(
  parameter int unsigned NUM_CFG = 8,
  parameter logic [15:0] CHIP_ID = 16'hC0DE
) (
  input  logic                   CLK,
  input  logic                   rst_n,
  input  logic                   reg_ce,
  input  logic                   reg_we,
  input  logic [7:0]             reg_addr_0b,
  input  logic [7:0]             reg_wdata_0b,
  input  logic [7:0]             reg_wdata_1b,
  output logic [7:0]             reg_rdata_0b,
  output logic [7:0]             reg_rdata_1b,
  output logic [16*NUM_CFG-1:0]  cfg_out,
  output logic                   core_start,
  input  logic                   core_done,
  output logic                   irq
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  localparam logic [7:0] AddrId      = 8'h00;
  localparam logic [7:0] AddrCtrl    = 8'h01;
  localparam logic [7:0] AddrStatus  = 8'h02;
  localparam logic [7:0] AddrScratch = 8'h03;

  logic [0:0]             state_q, state_d;
  logic                   core_start_q, core_start_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [7:0]             done_cnt_q, done_cnt_d;
  logic [15:0]            scratch_q, scratch_d;
  logic                   irq_en_q, irq_en_d;
  logic                   irq_q, irq_d;
  logic [15:0]            rdata_q, rdata_d;
  logic [16*NUM_CFG-1:0]  cfg_q, cfg_d;

  logic [15:0] wdata;
  logic        wr_en, rd_en, busy;
  logic        wr_ctrl, wr_status, wr_scratch;
  logic        soft_rst, start_req;
  logic        cfg_hit;
  logic [15:0] rd_val;

  assign wdata      = {reg_wdata_1b, reg_wdata_0b};
  assign wr_en      = reg_ce & reg_we;
  assign rd_en      = reg_ce & ~reg_we;
  assign busy       = (state_q == StRun);
  assign wr_ctrl    = wr_en & (reg_addr_0b == AddrCtrl);
  assign wr_status  = wr_en & (reg_addr_0b == AddrStatus);
  assign wr_scratch = wr_en & (reg_addr_0b == AddrScratch);
  assign soft_rst   = wr_ctrl & wdata[1];
  // SOFT_RST dominates a simultaneous START.
  assign start_req  = wr_ctrl & wdata[0] & ~wdata[1];

  always_comb begin
    cfg_hit = 1'b0;
    for (int unsigned k = 0; k < NUM_CFG; k++) begin
      if (reg_addr_0b == 8'(16 + k)) cfg_hit = 1'b1;
    end
  end

  // Read mux
  always_comb begin
    rd_val = 16'h0000;
    unique case (reg_addr_0b)
      AddrId:      rd_val = CHIP_ID;
      AddrCtrl:    rd_val = {7'b0, irq_en_q, 8'h00};
      AddrStatus:  rd_val = {done_cnt_q, 5'b0, err_q, done_q, busy};
      AddrScratch: rd_val = scratch_q;
      default: begin
        for (int unsigned k = 0; k < NUM_CFG; k++) begin
          if (reg_addr_0b == 8'(16 + k)) rd_val = cfg_q[16*k +: 16];
        end
      end
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    core_start_d = 1'b0;
    done_d       = done_q;
    err_d        = err_q;
    done_cnt_d   = done_cnt_q;
    scratch_d    = scratch_q;
    irq_en_d     = irq_en_q;
    cfg_d        = cfg_q;
    rdata_d      = rd_en ? rd_val : rdata_q;
    irq_d        = irq_en_q & (done_q | err_q);

    if (wr_scratch) scratch_d = wdata;
    // A soft-reset write leaves IRQ_EN as it was.
    if (wr_ctrl && !wdata[1]) irq_en_d = wdata[8];

    if (soft_rst) begin
      state_d    = StIdle;
      done_d     = 1'b0;
      err_d      = 1'b0;
      done_cnt_d = 8'h00;
      cfg_d      = '0;
    end else begin
      if (busy && core_done) begin
        state_d    = StIdle;
        done_cnt_d = done_cnt_q + 8'd1;
      end
      if (!busy && start_req) begin
        state_d      = StRun;
        core_start_d = 1'b1;
      end
      // Set events take priority over W1C in the same cycle.
      done_d = (busy & core_done) | (done_q & ~(wr_status & wdata[1]));
      err_d  = (busy & (start_req | (wr_en & cfg_hit))) | (err_q & ~(wr_status & wdata[2]));
      if (wr_en && !busy) begin
        for (int unsigned k = 0; k < NUM_CFG; k++) begin
          if (reg_addr_0b == 8'(16 + k)) cfg_d[16*k +: 16] = wdata;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      core_start_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      done_cnt_q   <= 8'h00;
      scratch_q    <= 16'h0000;
      irq_en_q     <= 1'b0;
      irq_q        <= 1'b0;
      rdata_q      <= 16'h0000;
      cfg_q        <= '0;
    end else begin
      state_q      <= state_d;
      core_start_q <= core_start_d;
      done_q       <= done_d;
      err_q        <= err_d;
      done_cnt_q   <= done_cnt_d;
      scratch_q    <= scratch_d;
      irq_en_q     <= irq_en_d;
      irq_q        <= irq_d;
      rdata_q      <= rdata_d;
      cfg_q        <= cfg_d;
    end
  end

  assign reg_rdata_0b = rdata_q[7:0];
  assign reg_rdata_1b = rdata_q[15:8];
  assign cfg_out      = cfg_q;
  assign core_start   = core_start_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_cfg_reg_bank.sv
// Directed self-checking bench for cfg_reg_bank (NUM_CFG = 8, CHIP_ID = 16'hC0DE).
// Inputs change and outputs are sampled on the falling edge of CLK.
module tb_cfg_reg_bank;

  logic         CLK = 1'b0;
  logic         rst_n;
  logic         reg_ce, reg_we, core_done;
  logic [7:0]   reg_addr_0b, reg_wdata_0b, reg_wdata_1b;
  logic [7:0]   reg_rdata_0b, reg_rdata_1b;
  logic [127:0] cfg_out;
  logic         core_start, irq;

  int checks = 0;
  int errors = 0;
  logic [15:0] rd;

  always #5 CLK = ~CLK;

  cfg_reg_bank #(.NUM_CFG(8), .CHIP_ID(16'hC0DE)) dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .reg_ce       (reg_ce),
    .reg_we       (reg_we),
    .reg_addr_0b  (reg_addr_0b),
    .reg_wdata_0b (reg_wdata_0b),
    .reg_wdata_1b (reg_wdata_1b),
    .reg_rdata_0b (reg_rdata_0b),
    .reg_rdata_1b (reg_rdata_1b),
    .cfg_out      (cfg_out),
    .core_start   (core_start),
    .core_done    (core_done),
    .irq          (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    reg_ce = 1'b0; reg_we = 1'b0; reg_addr_0b = 8'h00;
    reg_wdata_0b = 8'h00; reg_wdata_1b = 8'h00;
  endtask

  // Returns on the falling edge just after the write edge.
  task automatic wr(input logic [7:0] addr, input logic [15:0] data);
    @(negedge CLK);
    reg_ce = 1'b1; reg_we = 1'b1; reg_addr_0b = addr;
    {reg_wdata_1b, reg_wdata_0b} = data;
    @(negedge CLK);
    idle_bus();
  endtask

  task automatic rd_reg(input logic [7:0] addr, output logic [15:0] data);
    @(negedge CLK);
    reg_ce = 1'b1; reg_we = 1'b0; reg_addr_0b = addr;
    @(negedge CLK);
    idle_bus();
    data = {reg_rdata_1b, reg_rdata_0b};
  endtask

  task automatic done_pulse();
    @(negedge CLK);
    core_done = 1'b1;
    @(negedge CLK);
    core_done = 1'b0;
  endtask

  initial begin
    idle_bus();
    core_done = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_rdata", {16'h0, reg_rdata_1b, reg_rdata_0b}, 32'h0);
    chk("reset_cfg_out", {31'h0, |cfg_out}, 32'h0);
    chk("reset_core_start", {31'h0, core_start}, 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);
    rst_n = 1'b1;

    // First access right after reset release, then basic read/write.
    @(negedge CLK);
    reg_ce = 1'b1; reg_we = 1'b1; reg_addr_0b = 8'h10;
    {reg_wdata_1b, reg_wdata_0b} = 16'hA55A;
    @(negedge CLK);
    idle_bus();
    chk("cfg_out0_after_wr", {16'h0, cfg_out[15:0]}, 32'h0000A55A);
    rd_reg(8'h10, rd);
    chk("rd_cfg0_hi", {24'h0, rd[15:8]}, 32'hA5);
    chk("rd_cfg0_lo", {24'h0, rd[7:0]}, 32'h5A);
    rd_reg(8'h00, rd);
    chk("rd_id", {16'h0, rd}, 32'hC0DE);
    wr(8'h03, 16'hBEEF);
    chk("rdata_held_over_write", {16'h0, reg_rdata_1b, reg_rdata_0b}, 32'hC0DE);
    rd_reg(8'h7F, rd);
    chk("rd_unmapped_7f", {16'h0, rd}, 32'h0);
    rd_reg(8'h18, rd);
    chk("rd_past_last_cfg", {16'h0, rd}, 32'h0);
    rd_reg(8'h03, rd);
    chk("rd_scratch", {16'h0, rd}, 32'hBEEF);

    // Start/done handshake with interrupt.
    wr(8'h01, 16'h0101);
    chk("start_pulse_hi", {31'h0, core_start}, 32'h1);
    @(negedge CLK);
    chk("start_pulse_lo", {31'h0, core_start}, 32'h0);
    rd_reg(8'h02, rd);
    chk("status_busy", {16'h0, rd}, 32'h0001);
    rd_reg(8'h01, rd);
    chk("ctrl_readback", {16'h0, rd}, 32'h0100);
    done_pulse();
    chk("irq_not_yet", {31'h0, irq}, 32'h0);
    @(negedge CLK);
    chk("irq_set", {31'h0, irq}, 32'h1);
    rd_reg(8'h02, rd);
    chk("status_done", {16'h0, rd}, 32'h0102);
    wr(8'h02, 16'h0002);
    rd_reg(8'h02, rd);
    chk("status_after_w1c", {16'h0, rd}, 32'h0100);
    chk("irq_cleared", {31'h0, irq}, 32'h0);

    // Busy protection (this CTRL write also clears IRQ_EN).
    wr(8'h01, 16'h0001);
    chk("start2_pulse", {31'h0, core_start}, 32'h1);
    wr(8'h11, 16'h1234);
    chk("cfg1_blocked", {16'h0, cfg_out[31:16]}, 32'h0);
    wr(8'h01, 16'h0001);
    chk("no_pulse_in_run", {31'h0, core_start}, 32'h0);
    rd_reg(8'h02, rd);
    chk("status_err_busy", {16'h0, rd}, 32'h0105);
    @(negedge CLK);
    reg_ce = 1'b1; reg_we = 1'b1; reg_addr_0b = 8'h02;
    {reg_wdata_1b, reg_wdata_0b} = 16'h0002;
    core_done = 1'b1;
    @(negedge CLK);
    idle_bus();
    core_done = 1'b0;
    rd_reg(8'h02, rd);
    chk("done_set_wins", {16'h0, rd}, 32'h0206);
    wr(8'h02, 16'h0006);
    done_pulse();
    rd_reg(8'h02, rd);
    chk("idle_done_ignored", {16'h0, rd}, 32'h0200);
    rd_reg(8'h11, rd);
    chk("rd_cfg1_unchanged", {16'h0, rd}, 32'h0);

    // Counter wrap, starting from a soft-reset-cleared count.
    wr(8'h01, 16'h0002);
    rd_reg(8'h02, rd);
    chk("cnt_cleared", {16'h0, rd}, 32'h0);
    for (int i = 0; i < 256; i++) begin
      wr(8'h01, 16'h0001);
      done_pulse();
    end
    rd_reg(8'h02, rd);
    chk("cnt_wrap_256", {16'h0, rd}, 32'h0002);
    wr(8'h01, 16'h0001);
    done_pulse();
    rd_reg(8'h02, rd);
    chk("cnt_257", {16'h0, rd}, 32'h0102);

    // Soft reset in RUN.
    wr(8'h10, 16'hFFFF);
    wr(8'h01, 16'h0001);
    wr(8'h01, 16'h0003);
    chk("soft_no_pulse", {31'h0, core_start}, 32'h0);
    chk("soft_cfg_out", {31'h0, |cfg_out}, 32'h0);
    rd_reg(8'h02, rd);
    chk("soft_status", {16'h0, rd}, 32'h0);
    rd_reg(8'h10, rd);
    chk("soft_cfg0", {16'h0, rd}, 32'h0);
    rd_reg(8'h03, rd);
    chk("soft_scratch_kept", {16'h0, rd}, 32'hBEEF);

    // Asynchronous reset in RUN with irq asserted.
    wr(8'h01, 16'h0101);
    wr(8'h01, 16'h0101);
    repeat (2) @(negedge CLK);
    chk("pre_reset_irq", {31'h0, irq}, 32'h1);
    rd_reg(8'h02, rd);
    chk("pre_reset_status", {16'h0, rd}, 32'h0005);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rdata", {16'h0, reg_rdata_1b, reg_rdata_0b}, 32'h0);
    chk("async_irq", {31'h0, irq}, 32'h0);
    chk("async_cfg_out", {31'h0, |cfg_out}, 32'h0);
    chk("async_core_start", {31'h0, core_start}, 32'h0);
    @(negedge CLK);
    rst_n = 1'b1;
    done_pulse();
    chk("post_reset_no_start", {31'h0, core_start}, 32'h0);
    rd_reg(8'h02, rd);
    chk("post_reset_status", {16'h0, rd}, 32'h0);
    rd_reg(8'h01, rd);
    chk("post_reset_ctrl", {16'h0, rd}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
